// File: rtl/fifo_umbral.sv
// ============================================================================
// Module   : fifo_umbral
// Brief    : Synchronous FIFO with programmable almost-full/almost-empty
//            thresholds and a sticky overflow/underflow error flag.
//            Optional macro FIFO_ERROR_CLR_EN adds an error_clr input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  carga_umbral,
    input  logic [ADDR_WIDTH-1:0] umbral_alto_in,
    input  logic [ADDR_WIDTH-1:0] umbral_bajo_in,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
`ifdef FIFO_ERROR_CLR_EN
    input  logic                  error_clr,
`endif
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  fifo_error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] umbral_alto;
    logic [ADDR_WIDTH-1:0] umbral_bajo;

    logic pop_ok;
    logic push_ok;
    logic err_event;

    // A push into a full FIFO is still accepted when a pop frees a slot
    // in the same cycle; a pop never sees a same-cycle push.
    assign pop_ok    = pop && (count != '0);
    assign push_ok   = push && ((count != FULL_COUNT) || pop_ok);
    assign err_event = (push && !push_ok) || (pop && !pop_ok);

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == FULL_COUNT);
    assign almost_full  = (umbral_alto != '0) && (count >= {1'b0, umbral_alto});
    assign almost_empty = (umbral_bajo != '0) && (count <= {1'b0, umbral_bajo});

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            umbral_alto <= '0;
            umbral_bajo <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
        end else begin
            if (carga_umbral) begin
                umbral_alto <= umbral_alto_in;
                umbral_bajo <= umbral_bajo_in;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            valid_out <= pop_ok;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A fresh error in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_error <= 1'b0;
        end else if (err_event) begin
            fifo_error <= 1'b1;
`ifdef FIFO_ERROR_CLR_EN
        end else if (error_clr) begin
            fifo_error <= 1'b0;
`else
        end else begin
            fifo_error <= fifo_error;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_umbral.sv
// Directed self-checking bench for fifo_umbral (default 6-bit x 16 configuration).
`default_nettype none

module tb_fifo_umbral;

    logic       clk;
    logic       reset;
    logic       carga_umbral;
    logic [3:0] umbral_alto_in;
    logic [3:0] umbral_bajo_in;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
`ifdef FIFO_ERROR_CLR_EN
    logic       error_clr;
`endif
    logic [5:0] data_out;
    logic       valid_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_full;
    logic       almost_empty;
    logic       fifo_error;

    int tests_run;
    int tests_failed;

    fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .carga_umbral   (carga_umbral),
        .umbral_alto_in (umbral_alto_in),
        .umbral_bajo_in (umbral_bajo_in),
        .push           (push),
        .data_in        (data_in),
        .pop            (pop),
`ifdef FIFO_ERROR_CLR_EN
        .error_clr      (error_clr),
`endif
        .data_out       (data_out),
        .valid_out      (valid_out),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .fifo_error     (fifo_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [5:0] d);
        push    = 1'b1;
        data_in = d;
        tick();
        push    = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [5:0] exp);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check({tag, "_valid"}, valid_out, 1);
        check({tag, "_data"}, data_out, exp);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b0;
        carga_umbral   = 1'b0;
        umbral_alto_in = '0;
        umbral_bajo_in = '0;
        push           = 1'b1;
        data_in        = 6'h15;
        pop            = 1'b0;
`ifdef FIFO_ERROR_CLR_EN
        error_clr      = 1'b0;
`endif

        // Pushing while reset is held must have no effect.
        tick();
        tick();
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_error", fifo_error, 0);
        check("rst_data", data_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_af", almost_full, 0);
        check("rst_ae", almost_empty, 0);

        push  = 1'b0;
        reset = 1'b1;
        tick();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("uflow_error", fifo_error, 1);
        check("uflow_valid", valid_out, 0);
        check("uflow_empty", fifo_empty, 1);

        // Asynchronous assertion clears the error without a clock edge.
        reset = 1'b0;
        #1;
        check("async_rst_error", fifo_error, 0);
        reset = 1'b1;
        tick();

        // Thresholds alto=12, bajo=3; inputs change afterwards to show hold.
        carga_umbral   = 1'b1;
        umbral_alto_in = 4'd12;
        umbral_bajo_in = 4'd3;
        tick();
        carga_umbral   = 1'b0;
        umbral_alto_in = 4'd0;
        umbral_bajo_in = 4'd0;
        check("thr_ae_at0", almost_empty, 1);
        for (int n = 1; n <= 12; n++) begin
            push_word(6'(n));
            check($sformatf("thr_af_%0d", n), almost_full, (n >= 12) ? 1 : 0);
            check($sformatf("thr_ae_%0d", n), almost_empty, (n <= 3) ? 1 : 0);
        end
        for (int k = 1; k <= 12; k++) begin
            pop_check($sformatf("thr_pop_%0d", k), 6'(k));
            check($sformatf("thr_ae_pop_%0d", k), almost_empty, ((12 - k) <= 3) ? 1 : 0);
            check($sformatf("thr_af_pop_%0d", k), almost_full, 0);
        end
        tick();
        check("idle_valid", valid_out, 0);
        check("idle_data_hold", data_out, 6'd12);
        check("drain_empty", fifo_empty, 1);

        // Fill across the pointer wrap (write pointer starts at 12).
        for (int i = 1; i <= 16; i++) begin
            push_word(6'(i));
        end
        check("fill_full", fifo_full, 1);
        check("fill_error", fifo_error, 0);

        push    = 1'b1;
        pop     = 1'b1;
        data_in = 6'h11;
        tick();
        push = 1'b0;
        pop  = 1'b0;
        check("full_pp_full", fifo_full, 1);
        check("full_pp_error", fifo_error, 0);
        check("full_pp_valid", valid_out, 1);
        check("full_pp_data", data_out, 6'h01);

        push_word(6'h3F);
        check("oflow_error", fifo_error, 1);
        check("oflow_full", fifo_full, 1);
        check("oflow_valid", valid_out, 0);

        for (int i = 0; i < 16; i++) begin
            pop_check($sformatf("drain_%0d", i), (i == 15) ? 6'h11 : 6'(i + 2));
        end
        check("drain2_empty", fifo_empty, 1);

        for (int i = 0; i < 20; i++) begin
            push_word(6'(8'h20 + i));
            pop_check($sformatf("wrap_%0d", i), 6'(8'h20 + i));
        end

        // Simultaneous push+pop on an empty FIFO.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        push    = 1'b1;
        pop     = 1'b1;
        data_in = 6'h2A;
        tick();
        push = 1'b0;
        pop  = 1'b0;
        check("empty_pp_valid", valid_out, 0);
        check("empty_pp_error", fifo_error, 1);
        check("empty_pp_empty", fifo_empty, 0);
        pop_check("empty_pp_pop", 6'h2A);
        check("empty_pp_after", fifo_empty, 1);

        // Thresholds are 0 after reset: flags stay low at every occupancy.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        for (int n = 1; n <= 16; n++) begin
            push_word(6'(n));
            check($sformatf("thr0_af_%0d", n), almost_full, 0);
            check($sformatf("thr0_ae_%0d", n), almost_empty, 0);
        end
        check("thr0_full", fifo_full, 1);
        for (int k = 1; k <= 11; k++) begin
            pop_check($sformatf("thr0_pop_%0d", k), 6'(k));
        end
        carga_umbral   = 1'b1;
        umbral_alto_in = 4'd1;
        umbral_bajo_in = 4'd0;
        #1;
        check("reload_af_before", almost_full, 0);
        tick();
        carga_umbral = 1'b0;
        check("reload_af_after", almost_full, 1);
        check("reload_ae_after", almost_empty, 0);

`ifdef FIFO_ERROR_CLR_EN
        pop = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
        end
        pop = 1'b0;
        check("clr_pre_error", fifo_error, 1);
        error_clr = 1'b1;
        tick();
        check("clr_error", fifo_error, 0);
        pop = 1'b1;
        tick();
        pop       = 1'b0;
        error_clr = 1'b0;
        check("clr_vs_new_error", fifo_error, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
